// File: rtl/comparator_pkg.sv
// comparator_pkg: shared types, result encoding and sizing helpers for seq_mag_comparator
package comparator_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [2:0] RES_EQ = 3'b100;
    localparam logic [2:0] RES_GT = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/comp_chunk.sv
// comp_chunk: combinational CHUNK-bit unsigned magnitude compare
//   a, b  in   CHUNK  chunk operands
//   e     out  1      a == b
//   g     out  1      a > b
//   l     out  1      a < b
module comp_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             e,
    output logic             g,
    output logic             l
);
    assign e = a == b;
    assign g = a > b;
    assign l = a < b;
endmodule

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: multi-cycle MSB-first magnitude comparator with early exit
//   clk, rst     in   1      clock, synchronous active-high reset
//   start        in   1      request, accepted when ready
//   signed_mode  in   1      two's-complement compare, sampled on accept
//   a, b         in   WIDTH  operands, sampled on accept
//   ready        out  1      idle, able to accept
//   busy         out  1      scanning chunks
//   done         out  1      one-cycle pulse, flags valid from here
//   eq, gt, lt   out  1      result flags, held until next accept/reset
module seq_mag_comparator import comparator_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW = idx_w(NCHUNK);
    localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
        $error("seq_mag_comparator: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [2:0]       r_res;
    logic             r_done;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_e;
    logic             w_g;
    logic             w_l;
    logic             w_accept;
    logic             w_fin;

    assign w_ca = r_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_cb = r_b[int'(r_idx) * CHUNK +: CHUNK];

    comp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a (w_ca),
        .b (w_cb),
        .e (w_e),
        .g (w_g),
        .l (w_l)
    );

    always_comb begin
        w_accept     = start && r_state == IDLE;
        w_fin        = r_state == RUN && (!w_e || r_idx == '0);
        w_next_state = w_accept ? RUN : (w_fin ? IDLE : r_state);
    end

    // Signed mode flips the operand MSBs at capture (offset binary), so the
    // chunk scan itself is always unsigned and only the top chunk is affected.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= TOP;
            r_res   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_fin;
            if (w_accept) begin
                r_a   <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
                r_b   <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
                r_idx <= TOP;
                r_res <= '0;
            end else if (w_fin) begin
                r_res <= w_e ? RES_EQ : (w_g ? RES_GT : RES_LT);
            end else if (r_state == RUN) begin
                r_idx <= r_idx - IW'(1);
            end
        end
    end

    assign ready = r_state == IDLE;
    assign busy  = r_state == RUN;
    assign done  = r_done;
    assign eq    = r_res[2];
    assign gt    = r_res[1];
    assign lt    = r_res[0];
endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb_seq_mag_comparator: directed and random checks of seq_mag_comparator against a cycle model
module tb_seq_mag_comparator;
    localparam int W = 16;
    localparam int C = 2;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sm = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, busy, done, eq, gt, lt;

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(W), .CHUNK(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (sm),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .eq          (eq),
        .gt          (gt),
        .lt          (lt)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_res(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [W-1:0] sx;
        logic signed [W-1:0] sy;
        sx = x;
        sy = y;
        if (x == y) return 3'b100;
        if (s) return sx > sy ? 3'b010 : 3'b001;
        return x > y ? 3'b010 : 3'b001;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x ^ y;
        for (int c = N - 1; c >= 0; c--)
            if (d[c*C +: C] != '0) return N - c;
        return N;
    endfunction

    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [2:0] m_flags = '0;
    logic [2:0] m_res = '0;
    int         m_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_flags <= '0;
        end else if (!m_busy && start) begin
            m_busy  <= 1'b1;
            m_done  <= 1'b0;
            m_flags <= '0;
            m_res   <= ref_res(sm, a, b);
            m_cnt   <= ref_lat(a, b);
        end else if (m_busy && m_cnt == 1) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b1;
            m_flags <= m_res;
        end else begin
            m_done <= 1'b0;
            if (m_busy) m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ready", 32'(ready), 32'(!m_busy));
            check("m_busy", 32'(busy), 32'(m_busy));
            check("m_done", 32'(done), 32'(m_done));
            check("m_flags", 32'({eq, gt, lt}), 32'(m_flags));
        end
    end

    task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
        @(negedge clk);
        #1;
        sm = s;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(output int k, output int nb);
        k = 0;
        nb = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) nb++;
            if (k >= 30) begin
                check("done_timeout", 32'(k), 32'(N));
                break;
            end
            @(posedge clk);
            k++;
        end
    endtask

    task automatic op(input string nm, input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [2:0] er, input int el);
        int k, nb;
        issue(s, x, y, 1'b0);
        wait_done(k, nb);
        check({nm, "_lat"}, 32'(k), 32'(el));
        check({nm, "_res"}, 32'({eq, gt, lt}), 32'(er));
    endtask

    initial begin
        int k, nb;
        logic [W-1:0] x, y;
        logic s;
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k, nb;
        logic [W-1:0] x, y;
        logic s;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'({eq, gt, lt}), 32'd0);
        chk_en = 1'b1;

        op("u8000_7fff", 1'b0, 16'h8000, 16'h7FFF, 3'b010, 1);
        op("s8000_7fff", 1'b1, 16'h8000, 16'h7FFF, 3'b001, 1);
        op("u_eq", 1'b0, 16'h1234, 16'h1234, 3'b100, 8);
        issue(1'b1, 16'h1234, 16'h1234, 1'b0);
        wait_done(k, nb);
        check("s_eq_lat", 32'(k), 32'd8);
        check("s_eq_busy", 32'(nb), 32'd8);
        check("s_eq_res", 32'({eq, gt, lt}), 32'b100);
        op("lt_chunk4", 1'b0, 16'h1234, 16'h1334, 3'b001, 4);
        op("gt_chunk0", 1'b0, 16'h1235, 16'h1234, 3'b010, 8);
        op("s_neg_vs_neg", 1'b1, 16'hFFFE, 16'hFFFF, 3'b001, 8);

        issue(1'b0, 16'h1234, 16'h1234, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 16'h0000;
        b = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(k, nb);
        check("ignore_lat", 32'(k), 32'd6);
        check("ignore_res", 32'({eq, gt, lt}), 32'b100);

        issue(1'b0, 16'h1234, 16'h1234, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_flags", 32'({eq, gt, lt}), 32'd0);
        nb = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) nb++;
        end
        check("abort_no_done", 32'(nb), 32'd0);

        issue(1'b0, 16'h8000, 16'h7FFF, 1'b1);
        sm = 1'b1;
        a = 16'h1235;
        b = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_res1", 32'({eq, gt, lt}), 32'b010);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(k, nb);
        check("b2b_lat2", 32'(k), 32'd8);
        check("b2b_res2", 32'({eq, gt, lt}), 32'b010);

        for (int i = 0; i < 60; i++) begin
            s = 1'($urandom_range(0, 1));
            x = 16'($urandom);
            y = (i % 3 == 0) ? x ^ 16'(1 << $urandom_range(0, W - 1)) : (i % 7 == 0) ? x : 16'($urandom);
            op("rand", s, x, y, ref_res(s, x, y), ref_lat(x, y));
        end

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
